// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction fetch stage.
package fetch_pkg;

  localparam int          WORD_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    VALID = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Bundles the instruction-memory bus and the decode-side handshake of the fetch stage.
interface pc_fetch_stage_if;
  import fetch_pkg::*;

  // Memory side: imem_ack only counts while imem_req=1. Decode side: instr_valid is
  // held until the cycle stall=0 is seen with it high; that cycle consumes the word.
  logic              imem_req;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_ack;
  logic [WORD_W-1:0] imem_rdata;

  logic              stall;
  logic              branch_taken;
  logic [WORD_W-1:0] branch_target;
  logic [WORD_W-1:0] instr_out;
  logic [WORD_W-1:0] pc_out;
  logic              instr_valid;

  modport master (
    output imem_req, imem_addr, instr_out, pc_out, instr_valid,
    input  imem_ack, imem_rdata, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, pc_out, instr_valid,
    output imem_ack, imem_rdata, stall, branch_taken, branch_target
  );

endinterface

// File: rtl/pc_adder32.sv
// 32-bit PC incrementer; wraps modulo 2^32 with the carry dropped.
module pc_adder32
  import fetch_pkg::*;
(
  input  logic [WORD_W-1:0] i_pc,
  output logic [WORD_W-1:0] o_pc_inc
);

  assign o_pc_inc = i_pc + PC_INC;

endmodule

// File: rtl/pc_fetch_stage.sv
// Single-outstanding-request fetch stage: request, capture on ack, hand to decode.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  pc_fetch_stage_if.master  fetch,
  output fetch_state_t      o_dbg_state
);

  fetch_state_t      r_state;
  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_pc_out;
  logic              r_valid;

  fetch_state_t      w_next_state;
  logic              w_imem_req;
  logic              w_capture;
  logic              w_pc_load;
  logic              w_valid_next;
  logic [WORD_W-1:0] w_pc_plus4;
  logic [WORD_W-1:0] w_target;
  logic [WORD_W-1:0] w_pc_next;
  logic              w_unused;

  pc_adder32 u_adder (
    .i_pc     (r_pc),
    .o_pc_inc (w_pc_plus4)
  );

  // Redirect targets are always word aligned; the low bits are dropped on entry.
  assign w_target  = {fetch.branch_target[WORD_W-1:2], 2'b00};
  assign w_unused  = &{1'b0, fetch.branch_target[1:0]};
  assign w_pc_next = fetch.branch_taken ? w_target : w_pc_plus4;

  always_comb begin
    w_next_state = r_state;
    w_imem_req   = 1'b0;
    w_capture    = 1'b0;
    w_pc_load    = 1'b0;
    w_valid_next = r_valid;
    case (r_state)
      IDLE: begin
        w_next_state = REQ;
      end
      REQ: begin
        w_imem_req = 1'b1;
        if (fetch.branch_taken) begin
          w_pc_load    = 1'b1;
          w_valid_next = 1'b0;
          w_next_state = REQ;
        end else if (fetch.imem_ack) begin
          w_capture    = 1'b1;
          w_pc_load    = 1'b1;
          w_valid_next = 1'b1;
          w_next_state = VALID;
        end
      end
      VALID: begin
        if (fetch.branch_taken) begin
          w_pc_load    = 1'b1;
          w_valid_next = 1'b0;
          w_next_state = REQ;
        end else if (!fetch.stall) begin
          w_valid_next = 1'b0;
          w_next_state = REQ;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_pc_out <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_valid <= w_valid_next;
      if (w_pc_load) begin
        r_pc <= w_pc_next;
      end
      // Only a real capture updates the decode-facing word and its address.
      if (w_capture) begin
        r_instr  <= fetch.imem_rdata;
        r_pc_out <= r_pc;
      end
    end
  end

  assign fetch.imem_req    = w_imem_req;
  assign fetch.imem_addr   = r_pc;
  assign fetch.instr_out   = r_instr;
  assign fetch.pc_out      = r_pc_out;
  assign fetch.instr_valid = r_valid;
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: behavioural reference model plus literal checks.
module tb_pc_fetch_stage;
  import fetch_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pc_fetch_stage_if bus ();
  pc_fetch_stage_if bus_hi ();
  fetch_state_t dbg_state;
  fetch_state_t dbg_state_hi;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .fetch       (bus.master),
    .o_dbg_state (dbg_state)
  );

  pc_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
    .clk         (clk),
    .reset       (reset),
    .fetch       (bus_hi.master),
    .o_dbg_state (dbg_state_hi)
  );

  assign bus_hi.stall         = bus.stall;
  assign bus_hi.branch_taken  = bus.branch_taken;
  assign bus_hi.branch_target = bus.branch_target;
  assign bus_hi.imem_ack      = bus.imem_ack;
  assign bus_hi.imem_rdata    = bus.imem_rdata;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard helper
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "fresh" = first cycle after reset, "holding" = a word waits for decode.
  logic        m_known;
  logic        m_fresh;
  logic        m_holding;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc_of_instr;

  initial m_known = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_known       <= 1'b1;
      m_fresh       <= 1'b1;
      m_holding     <= 1'b0;
      m_pc          <= 32'h0000_0000;
      m_instr       <= 32'h0;
      m_pc_of_instr <= 32'h0;
    end else if (m_fresh) begin
      m_fresh <= 1'b0;
    end else if (bus.branch_taken) begin
      m_pc      <= bus.branch_target & 32'hFFFF_FFFC;
      m_holding <= 1'b0;
    end else if (!m_holding && bus.imem_ack) begin
      m_instr       <= bus.imem_rdata;
      m_pc_of_instr <= m_pc;
      m_holding     <= 1'b1;
      m_pc          <= 32'(64'(m_pc) + 64'd4);
    end else if (m_holding && !bus.stall) begin
      m_holding <= 1'b0;
    end
  end

  // compare process
  always @(negedge clk) begin
    if (m_known) begin
      check32("model_imem_req", 32'(bus.imem_req), 32'(!m_fresh && !m_holding));
      check32("model_imem_addr", bus.imem_addr, m_pc);
      check32("model_instr_valid", 32'(bus.instr_valid), 32'(m_holding));
      check32("model_instr_out", bus.instr_out, m_instr);
      check32("model_pc_out", bus.pc_out, m_pc_of_instr);
    end
  end

  // driver
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic br, input logic [31:0] tgt,
                       input logic ack, input logic [31:0] rdata);
    bus.stall         = st;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.imem_ack      = ack;
    bus.imem_rdata    = rdata;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic vld, input logic [31:0] instr, input logic [31:0] pco);
    check32({tag, "_req"}, 32'(bus.imem_req), 32'(req));
    check32({tag, "_addr"}, bus.imem_addr, addr);
    check32({tag, "_valid"}, 32'(bus.instr_valid), 32'(vld));
    check32({tag, "_instr"}, bus.instr_out, instr);
    check32({tag, "_pc_out"}, bus.pc_out, pco);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    step();
    reset = 1'b0;
    expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check32("reset_state", 32'(dbg_state), 32'(IDLE));
    check32("hi_reset_addr", bus_hi.imem_addr, 32'hFFFF_FFFC);

    // first fetch, ack in the first REQ cycle
    step();
    expect_out("first_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h2002_0001);
    step();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("first_fetch", 1'b0, 32'h4, 1'b1, 32'h2002_0001, 32'h0);
    check32("hi_pc_out", bus_hi.pc_out, 32'hFFFF_FFFC);
    check32("hi_wrap_addr", bus_hi.imem_addr, 32'h0000_0000);

    // hold in VALID under stall
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("stall_hold", 1'b0, 32'h4, 1'b1, 32'h2002_0001, 32'h0);
    end
    bus.stall = 1'b0;
    step();
    expect_out("stall_release", 1'b1, 32'h4, 1'b0, 32'h2002_0001, 32'h0);

    // ack arrives only after four waiting cycles
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("ack_wait", 1'b1, 32'h4, 1'b0, 32'h2002_0001, 32'h0);
    end
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hA5A5_0004);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("late_ack", 1'b0, 32'h8, 1'b1, 32'hA5A5_0004, 32'h4);
    step();
    expect_out("consume", 1'b1, 32'h8, 1'b0, 32'hA5A5_0004, 32'h4);

    // branch coincident with ack discards the returned word
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b1, 32'hDEAD_BEEF);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("branch_ack", 1'b1, 32'h100, 1'b0, 32'hA5A5_0004, 32'h4);

    // branch during a stalled VALID wins over stall
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_2222);
    step();
    expect_out("fetch_100", 1'b0, 32'h104, 1'b1, 32'h1111_2222, 32'h100);
    drive(1'b1, 1'b1, 32'h0000_0202, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("branch_stall", 1'b1, 32'h200, 1'b0, 32'h1111_2222, 32'h100);

    // reset while stalled in VALID, with branch and ack also asserted
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_4444);
    step();
    expect_out("fetch_200", 1'b0, 32'h204, 1'b1, 32'h3333_4444, 32'h200);
    drive(1'b1, 1'b1, 32'h0000_0300, 1'b1, 32'h5555_6666);
    reset = 1'b1;
    step();
    reset = 1'b0;
    expect_out("reset_valid", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    check32("reset_valid_state", 32'(dbg_state), 32'(IDLE));

    // stale ack during the IDLE cycle must not be captured
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h7777_8888);
    step();
    bus.imem_ack = 1'b0;
    expect_out("stale_ack", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    check32("stale_ack_state", 32'(dbg_state), 32'(REQ));

    // reset during REQ abandons the request; branch in IDLE ignored
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h9999_AAAA);
    expect_out("idle_branch", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    step();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_out("refetch", 1'b0, 32'h4, 1'b1, 32'h9999_AAAA, 32'h0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
PC_FETCH_STAGE -- requirements
Module: pc_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset (word-aligned).
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 stall  input  1  downstream decode not ready; hold the current instruction.
REQ-005 branch_taken  input  1  redirect request, valid for one cycle.
REQ-006 branch_target  input  32  redirect address; bits [1:0] ignored and forced to 2'b00.
REQ-007 imem_req  output  1  instruction memory read request.
REQ-008 imem_addr  output  32  read address, equal to the PC register.
REQ-009 imem_ack  input  1  memory returns imem_rdata this cycle; ignored when imem_req=0.
REQ-010 imem_rdata  input  32  instruction word from memory.
REQ-011 instr_out  output  32  fetched instruction presented to decode.
REQ-012 pc_out  output  32  address of instr_out.
REQ-013 instr_valid  output  1  instr_out/pc_out hold a valid instruction.

Function
REQ-014 FSM states: IDLE, REQ, VALID; IDLE exists only for the first cycle after reset.
REQ-015 IDLE -> REQ unconditionally on the next edge; imem_req=0 in IDLE.
REQ-016 In REQ: imem_req=1, imem_addr=pc; stay in REQ while imem_ack=0.
REQ-017 REQ with imem_ack=1: instr_out<=imem_rdata, pc_out<=pc, instr_valid<=1, pc<=pc+4, next state VALID (1-cycle latency ack->instr_valid).
REQ-018 In VALID: imem_req=0; stall=1 holds instr_out, pc_out, instr_valid and pc unchanged.
REQ-019 VALID with stall=0: the instruction is consumed, instr_valid<=0, next state REQ; peak throughput is one instruction per 2 cycles.
REQ-020 PC increment is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag raised.
REQ-021 branch_taken=1 in any non-IDLE state has priority over ack and stall: pc<={branch_target[31:2],2'b00}, instr_valid<=0, next state REQ.
REQ-022 branch_taken with imem_ack in the same cycle discards imem_rdata; instr_out and pc_out keep their previous values.
REQ-023 branch_taken in IDLE is ignored.
REQ-024 Next-PC selection (pc+4 vs redirect target) uses a 32-bit 2:1 select with branch_taken as select.
REQ-025 instr_out and pc_out change only on a captured ack, never on stall or branch.

Reset
REQ-026 reset=1 overrides all inputs, including branch_taken and imem_ack, which are ignored that cycle.
REQ-027 After a reset edge: pc=RESET_PC, state=IDLE, imem_req=0, imem_addr=RESET_PC, instr_out=0, pc_out=0, instr_valid=0.
REQ-028 Reset asserted during REQ abandons the outstanding request; a late ack after reset is ignored until REQ is re-entered.

Structure
REQ-029 Package fetch_pkg holds the state encoding (IDLE=2'd0, REQ=2'd1, VALID=2'd2), PC_INC=32'd4 and the 32-bit word width constant.
REQ-030 A single sub-module, pc_adder32, a 32-bit incrementer producing pc+4 with carry-out discarded.

Verification
REQ-031 reset 2 cycles, release, ack in first REQ cycle with rdata=32'h2002_0001 -> next cycle instr_valid=1, instr_out=32'h2002_0001, pc_out=0, imem_addr=4.
REQ-032 stall=1 for 3 cycles in VALID -> instr_out, pc_out, instr_valid constant, imem_req=0; stall=0 -> next cycle REQ with addr 4.
REQ-033 ack delayed 4 cycles -> imem_req=1 and imem_addr stable throughout, instr_valid=0 until the cycle after ack.
REQ-034 branch_taken with target 32'h0000_0103 coincident with ack -> data discarded, next imem_addr=32'h0000_0100, instr_valid=0.
REQ-035 RESET_PC=32'hFFFF_FFFC, one fetch -> pc_out=32'hFFFF_FFFC, next imem_addr=32'h0000_0000.
REQ-036 reset asserted while in VALID with stall=1 -> next cycle all outputs at reset values, state IDLE.
